// File: rtl/siso_channel_arbiter.sv
// Round-robin arbiter that loads one requester's word and shifts it out MSB-first,
// then pulses that requester's done flag and re-arbitrates.
module siso_channel_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          serial_out,
    output logic                          frame_valid,
    output logic [NUM_REQ-1:0]            done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_last, r_win, w_win;
    logic                    w_any;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_REQ-1:0]      r_gnt, r_done;
    logic                    r_busy, r_sout, r_fv;

    // Scan from the slot after the last winner, wrapping, so the last winner is lowest priority.
    always_comb begin
        int idx;
        w_win = '0;
        w_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_any && req[idx]) begin
                w_win = IDX_W'(idx);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(DATA_WIDTH-1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last  <= IDX_W'(NUM_REQ-1);
            r_win   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_sout  <= 1'b0;
            r_fv    <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_gnt   <= NUM_REQ'(1) << w_win;
                    r_win   <= w_win;
                    r_shift <= data_in[w_win*DATA_WIDTH +: DATA_WIDTH];
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                S_SHIFT: begin
                    r_sout  <= r_shift[DATA_WIDTH-1];
                    r_shift <= r_shift << 1;
                    r_fv    <= 1'b1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_fv   <= 1'b0;
                    r_sout <= 1'b0;
                    r_done <= NUM_REQ'(1) << r_win;
                    r_gnt  <= '0;
                    r_busy <= 1'b0;
                    r_last <= r_win;
                end
                default: ;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign serial_out  = r_sout;
    assign frame_valid = r_fv;
    assign done        = r_done;
endmodule

// File: tb/tb_siso_channel_arbiter.sv
// Directed bench: per-cycle expected waveform rows plus hand-written reset sequences.
module tb_siso_channel_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] data_in;
    logic [NR-1:0]   gnt, done;
    logic            busy, serial_out, frame_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*DW-1:0] din;
        logic [NR-1:0]    gnt;
        logic             busy;
        logic             sout;
        logic             fv;
        logic [NR-1:0]    done;
    } vec_t;

    vec_t q[$];

    siso_channel_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .gnt(gnt), .busy(busy), .serial_out(serial_out),
        .frame_valid(frame_valid), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NR-1:0] eg, input logic eb,
                           input logic es, input logic ef, input logic [NR-1:0] ed);
        chk({tag, ".gnt"},  32'(gnt), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".sout"}, 32'(serial_out), 32'(es));
        chk({tag, ".fv"},   32'(frame_valid), 32'(ef));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic push(input logic [NR-1:0] r, input logic [NR*DW-1:0] d, input logic [NR-1:0] g,
                        input logic b, input logic s, input logic f, input logic [NR-1:0] dn);
        vec_t v;
        v.req = r; v.din = d; v.gnt = g; v.busy = b; v.sout = s; v.fv = f; v.done = dn;
        q.push_back(v);
    endtask

    // Grant cycle, DW bit cycles (MSB first), then the done cycle.
    task automatic add_frame(input logic [NR-1:0] r, input logic [NR*DW-1:0] d,
                             input logic [NR-1:0] oh, input logic [DW-1:0] w);
        push(r, d, oh, 1'b1, 1'b0, 1'b0, '0);
        for (int i = DW-1; i >= 0; i--) push(r, d, oh, 1'b1, w[i], 1'b1, '0);
        push(r, d, '0, 1'b0, 1'b0, 1'b0, oh);
    endtask

    task automatic add_idle(input logic [NR-1:0] r, input logic [NR*DW-1:0] d);
        push(r, d, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < q.size(); i++) begin
            req = q[i].req;
            data_in = q[i].din;
            @(posedge clk);
            @(negedge clk);
            chk_all($sformatf("%s[%0d]", name, i), q[i].gnt, q[i].busy, q[i].sout, q[i].fv, q[i].done);
        end
        q.delete();
    endtask

    initial begin
        int base;
        int waited;
        vec_t v;

        // Reset held: outputs stay zero while inputs toggle.
        reset = 1'b0;
        req = '0;
        data_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 4'b1111 >> i;
            data_in = $urandom;
            @(posedge clk);
            #1;
            chk_all($sformatf("rst_hold%0d", i), '0, 1'b0, 1'b0, 1'b0, '0);
        end
        @(negedge clk);
        req = '0;
        reset = 1'b1;
        add_idle('0, '0);
        add_idle('0, '0);
        run_table("rst_idle");

        // Fairness: all four request continuously, pointer starts at NR-1.
        for (int f = 0; f < 5; f++) begin
            logic [7:0] w;
            w = 8'h01 << (f % 4);
            add_frame(4'b1111, 32'h0804_0201, 4'b0001 << (f % 4), w);
        end
        add_idle('0, '0);
        run_table("fair");

        // Single frame from requester 1.
        add_frame(4'b0010, 32'h0000_A500, 4'b0010, 8'hA5);
        add_idle('0, '0);
        run_table("single");

        // Requester 2 drops req and its data after bit 3; frame must still finish intact.
        add_frame(4'b0100, 32'h00FF_0000, 4'b0100, 8'hFF);
        base = q.size() - (DW + 2);
        for (int k = 4; k <= DW + 1; k++) begin
            v = q[base + k];
            v.req = '0;
            v.din = '0;
            q[base + k] = v;
        end
        add_idle('0, '0);
        run_table("drop");

        // Wrap: after requester 3, requester 0 wins over 3, then 3 follows back-to-back.
        add_frame(4'b1000, 32'h3C00_0000, 4'b1000, 8'h3C);
        add_idle('0, '0);
        add_frame(4'b1001, 32'hC300_0081, 4'b0001, 8'h81);
        add_frame(4'b1000, 32'hC300_0081, 4'b1000, 8'hC3);
        add_idle('0, '0);
        run_table("wrap");

        // Reset mid-frame during bit 4 of a requester-3 frame.
        req = 4'b1000;
        data_in = 32'hFF00_0000;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.gnt_before", 32'(gnt), 32'h8);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrst.fv_before", 32'(frame_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("midrst.async", '0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req = ~req;
            @(posedge clk);
            #1;
            chk_all($sformatf("midrst.hold%0d", i), '0, 1'b0, 1'b0, 1'b0, '0);
        end
        @(negedge clk);
        req = 4'b0101;
        data_in = 32'h0000_0055;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.regrant", 32'(gnt), 32'h1);
        waited = 0;
        while (done == '0 && waited < 20) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        chk("midrst.done_seen", 32'(waited < 20), 32'h1);
        chk("midrst.done_val", 32'(done), 32'h1);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        chk_all("midrst.tail", '0, 1'b0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
